// File: rtl/mem_arbiter_pkg.sv
// Shared command codes, response tags and request record for the memory arbiter.
package mem_arbiter_pkg;

    localparam logic [1:0] CMD_NOOP    = 2'd0;
    localparam logic [1:0] CMD_REFRESH = 2'd1;
    localparam logic [1:0] CMD_READ    = 2'd2;
    localparam logic [1:0] CMD_WRITE   = 2'd3;

    localparam logic TAG_MC   = 1'b0;
    localparam logic TAG_DISP = 1'b1;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [21:0] addr;
        logic [63:0] dta;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// 1-bit tag FIFO remembering which requester issued each outstanding read.
module mem_arb_tag_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_tag,
    input  logic pop,
    output logic pop_tag,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [DEPTH-1:0] mem;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_tag = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_tag;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates refresh, display, motion-comp and framestore traffic onto the memory
// request FIFO and routes read responses back. Refresh scheduler needs MEM_ARB_REFRESH_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 1560,
    parameter int TAG_DEPTH        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fwr_valid,
    input  logic [21:0] fwr_addr,
    input  logic [63:0] fwr_dta,
    output logic        fwr_en,
    input  logic        mc_valid,
    input  logic [21:0] mc_addr,
    output logic        mc_en,
    input  logic        disp_valid,
    input  logic [21:0] disp_addr,
    output logic        disp_en,
    output logic [1:0]  mem_req_wr_cmd,
    output logic [21:0] mem_req_wr_addr,
    output logic [63:0] mem_req_wr_dta,
    output logic        mem_req_wr_en,
    input  logic        mem_req_wr_almost_full,
    input  logic [63:0] mem_res_rd_dta,
    input  logic        mem_res_rd_valid,
    output logic        mem_res_rd_en,
    output logic [63:0] mc_res_dta,
    output logic        mc_res_valid,
    output logic [63:0] disp_res_dta,
    output logic        disp_res_valid,
    output logic        err
);

    logic     issue_ok, rd_ok;
    logic     g_ref, g_disp, g_mc, g_fwr;
    logic     mc_try, fwr_try;
    logic     rr;
    logic [2:0] pend;
    logic     tag_full, tag_empty, tag_head, tag_pop;
    mem_req_t sel;

    always_comb begin
        issue_ok = rst & ~mem_req_wr_almost_full;
        rd_ok    = issue_ok & ~tag_full;
        g_ref    = issue_ok & (pend != 3'd0);
        g_disp   = ~g_ref & rd_ok & disp_valid;
        mc_try   = ~g_ref & ~g_disp & rd_ok & mc_valid;
        fwr_try  = ~g_ref & ~g_disp & issue_ok & fwr_valid;
        // rr=0 favours motion comp; the loser only wins if the favoured side is idle.
        g_mc     = mc_try & (~rr | ~fwr_try);
        g_fwr    = fwr_try & (rr | ~mc_try);

        sel.cmd  = CMD_NOOP;
        sel.addr = '0;
        sel.dta  = '0;
        if (g_ref) begin
            sel.cmd  = CMD_REFRESH;
        end else if (g_disp) begin
            sel.cmd  = CMD_READ;
            sel.addr = disp_addr;
        end else if (g_mc) begin
            sel.cmd  = CMD_READ;
            sel.addr = mc_addr;
        end else if (g_fwr) begin
            sel.cmd  = CMD_WRITE;
            sel.addr = fwr_addr;
            sel.dta  = fwr_dta;
        end
    end

    assign fwr_en  = g_fwr;
    assign mc_en   = g_mc;
    assign disp_en = g_disp;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req_wr_en   <= 1'b0;
            mem_req_wr_cmd  <= CMD_NOOP;
            mem_req_wr_addr <= '0;
            mem_req_wr_dta  <= '0;
            rr              <= 1'b0;
        end else begin
            mem_req_wr_en   <= g_ref | g_disp | g_mc | g_fwr;
            mem_req_wr_cmd  <= sel.cmd;
            mem_req_wr_addr <= sel.addr;
            mem_req_wr_dta  <= sel.dta;
            if (g_mc)       rr <= 1'b1;
            else if (g_fwr) rr <= 1'b0;
        end
    end

`ifdef MEM_ARB_REFRESH_EN
    logic [31:0] ref_cnt;
    logic        ref_wrap;

    assign ref_wrap = (ref_cnt == 32'(REFRESH_INTERVAL - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            ref_cnt <= '0;
            pend    <= '0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + 32'd1;
            // A wrap coinciding with a refresh grant leaves the backlog unchanged.
            case ({ref_wrap, g_ref})
                2'b10:   if (pend != 3'd7) pend <= pend + 3'd1;
                2'b01:   pend <= pend - 3'd1;
                default: ;
            endcase
        end
    end
`else
    assign pend = 3'd0;
`endif

    mem_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (g_mc | g_disp),
        .push_tag (g_disp),
        .pop      (tag_pop),
        .pop_tag  (tag_head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    // Untagged responses are still drained so a stray word cannot wedge the FIFO.
    assign tag_pop       = mem_res_rd_valid & ~tag_empty;
    assign mem_res_rd_en = rst & mem_res_rd_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mc_res_valid   <= 1'b0;
            mc_res_dta     <= '0;
            disp_res_valid <= 1'b0;
            disp_res_dta   <= '0;
            err            <= 1'b0;
        end else begin
            mc_res_valid   <= tag_pop & (tag_head == TAG_MC);
            disp_res_valid <= tag_pop & (tag_head == TAG_DISP);
            if (tag_pop && tag_head == TAG_MC)   mc_res_dta   <= mem_res_rd_dta;
            if (tag_pop && tag_head == TAG_DISP) disp_res_dta <= mem_res_rd_dta;
            if (mem_res_rd_valid && tag_empty)   err          <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter with a queue-based reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TAGD = 4;
    localparam int RI   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fwr_valid = 1'b0;
    logic [21:0] fwr_addr = '0;
    logic [63:0] fwr_dta = '0;
    logic        fwr_en;
    logic        mc_valid = 1'b0;
    logic [21:0] mc_addr = '0;
    logic        mc_en;
    logic        disp_valid = 1'b0;
    logic [21:0] disp_addr = '0;
    logic        disp_en;
    logic [1:0]  mem_req_wr_cmd;
    logic [21:0] mem_req_wr_addr;
    logic [63:0] mem_req_wr_dta;
    logic        mem_req_wr_en;
    logic        mem_req_wr_almost_full = 1'b0;
    logic [63:0] mem_res_rd_dta = '0;
    logic        mem_res_rd_valid = 1'b0;
    logic        mem_res_rd_en;
    logic [63:0] mc_res_dta;
    logic        mc_res_valid;
    logic [63:0] disp_res_dta;
    logic        disp_res_valid;
    logic        err;

    mem_arbiter #(.REFRESH_INTERVAL(RI), .TAG_DEPTH(TAGD)) dut (
        .clk(clk), .rst(rst),
        .fwr_valid(fwr_valid), .fwr_addr(fwr_addr), .fwr_dta(fwr_dta), .fwr_en(fwr_en),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_en(mc_en),
        .disp_valid(disp_valid), .disp_addr(disp_addr), .disp_en(disp_en),
        .mem_req_wr_cmd(mem_req_wr_cmd), .mem_req_wr_addr(mem_req_wr_addr),
        .mem_req_wr_dta(mem_req_wr_dta), .mem_req_wr_en(mem_req_wr_en),
        .mem_req_wr_almost_full(mem_req_wr_almost_full),
        .mem_res_rd_dta(mem_res_rd_dta), .mem_res_rd_valid(mem_res_rd_valid),
        .mem_res_rd_en(mem_res_rd_en),
        .mc_res_dta(mc_res_dta), .mc_res_valid(mc_res_valid),
        .disp_res_dta(disp_res_dta), .disp_res_valid(disp_res_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    // Stimulus sources: requester FIFOs and the memory response FIFO.
    logic [85:0] fwr_q[$];
    logic [21:0] mc_q[$];
    logic [21:0] disp_q[$];
    logic [63:0] res_q[$];
    logic s_fwr = 1'b0, s_mc = 1'b0, s_disp = 1'b0, s_rd = 1'b0;
    bit   auto_resp = 1'b0;

    // Reference model state.
    int          m_pend = 0;
    int          m_cnt = 0;
    bit          m_rr = 1'b0;
    bit          m_tags[$];
    logic        m_err = 1'b0;
    logic        e_wr_en = 1'b0;
    logic [1:0]  e_cmd = CMD_NOOP;
    logic [21:0] e_addr = '0;
    logic [63:0] e_dta = '0;
    logic        e_mc_v = 1'b0, e_disp_v = 1'b0;
    logic [63:0] e_mc_d = '0, e_disp_d = '0;

    int n_checks = 0;
    int n_fail = 0;

    logic [223:0] dut_vec;
    assign dut_vec = {fwr_en, mc_en, disp_en, mem_res_rd_en, mem_req_wr_en, mem_req_wr_cmd,
                      mem_req_wr_addr, mem_req_wr_dta, mc_res_valid, mc_res_dta,
                      disp_res_valid, disp_res_dta, err};

    // 0 none, 1 refresh, 2 disp, 3 mc, 4 fwr
    function automatic int exp_grant();
        bit rd;
        if (!rst || mem_req_wr_almost_full) return 0;
        if (m_pend > 0) return 1;
        rd = (m_tags.size() < TAGD);
        if (rd && disp_valid) return 2;
        if (rd && mc_valid && (!m_rr || !fwr_valid)) return 3;
        if (fwr_valid) return 4;
        return 0;
    endfunction

    function automatic logic [223:0] exp_vec();
        int g;
        g = exp_grant();
        return {g == 4, g == 3, g == 2, rst & mem_res_rd_valid, e_wr_en, e_cmd, e_addr, e_dta,
                e_mc_v, e_mc_d, e_disp_v, e_disp_d, m_err};
    endfunction

    task automatic model_update();
        int g;
        bit wrap, t;
        g = exp_grant();
        if (!rst) begin
            m_pend = 0; m_cnt = 0; m_rr = 1'b0; m_tags.delete(); m_err = 1'b0;
            e_wr_en = 1'b0; e_cmd = CMD_NOOP; e_addr = '0; e_dta = '0;
            e_mc_v = 1'b0; e_disp_v = 1'b0; e_mc_d = '0; e_disp_d = '0;
        end else begin
            e_wr_en = (g != 0);
            e_cmd = CMD_NOOP; e_addr = '0; e_dta = '0;
            case (g)
                1: e_cmd = CMD_REFRESH;
                2: begin e_cmd = CMD_READ; e_addr = disp_addr; end
                3: begin e_cmd = CMD_READ; e_addr = mc_addr; end
                4: begin e_cmd = CMD_WRITE; e_addr = fwr_addr; e_dta = fwr_dta; end
                default: ;
            endcase
            if (g == 3) m_rr = 1'b1;
            else if (g == 4) m_rr = 1'b0;
`ifdef MEM_ARB_REFRESH_EN
            wrap = (m_cnt == RI - 1);
            m_cnt = wrap ? 0 : m_cnt + 1;
            if (wrap && g != 1) m_pend = (m_pend < 7) ? m_pend + 1 : 7;
            else if (!wrap && g == 1) m_pend = m_pend - 1;
`else
            wrap = 1'b0;
`endif
            e_mc_v = 1'b0; e_disp_v = 1'b0;
            if (mem_res_rd_valid) begin
                if (m_tags.size() > 0) begin
                    t = m_tags.pop_front();
                    if (t) begin e_disp_v = 1'b1; e_disp_d = mem_res_rd_dta; end
                    else begin e_mc_v = 1'b1; e_mc_d = mem_res_rd_dta; end
                end else begin
                    m_err = 1'b1;
                end
            end
            if (g == 2) m_tags.push_back(1'b1);
            if (g == 3) m_tags.push_back(1'b0);
        end
    endtask

    task automatic clear_reqs();
        fwr_q.delete(); mc_q.delete(); disp_q.delete();
        s_fwr = 1'b0; s_mc = 1'b0; s_disp = 1'b0;
    endtask

    // One clock: model advances at posedge, inputs change at negedge, outputs sampled 1 later.
    task automatic step(input logic r, input logic a, input logic [2:0] gate);
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (s_fwr && fwr_q.size() > 0) fwr_q.delete(0);
        if (s_mc && mc_q.size() > 0) mc_q.delete(0);
        if (s_disp && disp_q.size() > 0) disp_q.delete(0);
        if (s_rd && res_q.size() > 0) res_q.delete(0);
        rst = r;
        mem_req_wr_almost_full = a;
        fwr_valid = gate[0] && (fwr_q.size() > 0);
        {fwr_addr, fwr_dta} = fwr_valid ? fwr_q[0] : '0;
        mc_valid = gate[1] && (mc_q.size() > 0);
        mc_addr = mc_valid ? mc_q[0] : '0;
        disp_valid = gate[2] && (disp_q.size() > 0);
        disp_addr = disp_valid ? disp_q[0] : '0;
        mem_res_rd_valid = (res_q.size() > 0);
        mem_res_rd_dta = mem_res_rd_valid ? res_q[0] : '0;
        #1;
        s_fwr = fwr_en; s_mc = mc_en; s_disp = disp_en; s_rd = mem_res_rd_en;
        if (auto_resp && mem_req_wr_en && mem_req_wr_cmd == CMD_READ)
            res_q.push_back({$urandom(), $urandom()});
    endtask

    task automatic test_reset();
        fwr_q.push_back({22'h3, 64'h5}); mc_q.push_back(22'h7); disp_q.push_back(22'h9);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'b111);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL reset_vec: got %h exp %h", dut_vec, exp_vec());
            end
            n_checks++;
            if ({fwr_en, mc_en, disp_en, mem_req_wr_en, mem_req_wr_cmd, err, mc_res_valid, disp_res_valid} !== 9'b0) begin
                n_fail++; $display("FAIL reset_outputs: got %b exp 0",
                    {fwr_en, mc_en, disp_en, mem_req_wr_en, mem_req_wr_cmd, err, mc_res_valid, disp_res_valid});
            end
        end
        clear_reqs();
        repeat (2) step(1'b1, 1'b0, 3'b111);
    endtask

    task automatic test_write_burst();
        int nen, nwr;
        nen = 0; nwr = 0;
        for (int k = 0; k < 3; k++) fwr_q.push_back({22'(16 + k), 64'(10 + k)});
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 3'b111);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL write_vec: got %h exp %h", dut_vec, exp_vec());
            end
            if (fwr_en) nen++;
            if (mem_req_wr_en && mem_req_wr_cmd == CMD_WRITE) begin
                n_checks++;
                if ({mem_req_wr_addr, mem_req_wr_dta} !== {22'(16 + nwr), 64'(10 + nwr)}) begin
                    n_fail++; $display("FAIL write_data: got %h/%h exp %h/%h", mem_req_wr_addr,
                        mem_req_wr_dta, 22'(16 + nwr), 64'(10 + nwr));
                end
                nwr++;
            end
        end
        n_checks++;
        if (nen !== 3 || nwr !== 3) begin
            n_fail++; $display("FAIL write_count: got en=%0d pushes=%0d exp 3/3", nen, nwr);
        end
    endtask

    task automatic test_rr_priority();
        int nmc, nfwr;
        nmc = 0; nfwr = 0;
        auto_resp = 1'b1;
        for (int k = 0; k < 30; k++) begin
            mc_q.push_back(22'($urandom()));
            fwr_q.push_back({22'($urandom()), $urandom(), $urandom()});
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin disp_q.push_back(22'h2A0); disp_q.push_back(22'h2A1); end
            step(1'b1, 1'b0, 3'b111);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL rr_vec: got %h exp %h", dut_vec, exp_vec());
            end
            if (mc_en) nmc++;
            if (fwr_en) nfwr++;
        end
        n_checks++;
        if (nmc - nfwr > 1 || nfwr - nmc > 1) begin
            n_fail++; $display("FAIL rr_balance: got mc=%0d fwr=%0d exp within 1", nmc, nfwr);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 3'b111);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL bp_vec: got %h exp %h", dut_vec, exp_vec());
            end
            n_checks++;
            if ({fwr_en, mc_en, disp_en} !== 3'b000 || (i > 0 && mem_req_wr_en !== 1'b0)) begin
                n_fail++; $display("FAIL bp_blocked: got en=%b push=%b exp 0", {fwr_en, mc_en, disp_en}, mem_req_wr_en);
            end
        end
        step(1'b1, 1'b0, 3'b111);
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL bp_release_vec: got %h exp %h", dut_vec, exp_vec());
        end
        step(1'b1, 1'b0, 3'b111);
        n_checks++;
        if (mem_req_wr_en !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_push: got %b exp 1", mem_req_wr_en);
        end
        clear_reqs();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 3'b111);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL drain_vec: got %h exp %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_read_route();
        int mc_at, disp_at;
        mc_at = -1; disp_at = -1;
        auto_resp = 1'b0;
        mc_q.push_back(22'h100);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 3'b111);
            if (s_mc) break;
        end
        disp_q.push_back(22'h200);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 3'b111);
            if (s_disp) break;
        end
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL route_issue_vec: got %h exp %h", dut_vec, exp_vec());
        end
        repeat (2) step(1'b1, 1'b0, 3'b111);
        res_q.push_back(64'h1111); res_q.push_back(64'h2222);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 3'b111);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL route_vec: got %h exp %h", dut_vec, exp_vec());
            end
            if (mc_res_valid) begin
                mc_at = i; n_checks++;
                if (mc_res_dta !== 64'h1111) begin
                    n_fail++; $display("FAIL route_mc_data: got %h exp 1111", mc_res_dta);
                end
            end
            if (disp_res_valid) begin
                disp_at = i; n_checks++;
                if (disp_res_dta !== 64'h2222) begin
                    n_fail++; $display("FAIL route_disp_data: got %h exp 2222", disp_res_dta);
                end
            end
        end
        n_checks++;
        if (mc_at < 0 || disp_at != mc_at + 1 || err !== 1'b0) begin
            n_fail++; $display("FAIL route_order: got mc@%0d disp@%0d err=%b exp consecutive, err 0", mc_at, disp_at, err);
        end
        res_q.push_back(64'hDEAD);
        repeat (2) step(1'b1, 1'b0, 3'b111);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL err_set: got %b exp 1", err);
        end
        repeat (3) step(1'b1, 1'b0, 3'b111);
        n_checks++;
        if (err !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL err_sticky: got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_tag_full();
        int nrd, nwr, nref;
        nrd = 0; nwr = 0; nref = 0;
        for (int k = 0; k < 40; k++) begin
            mc_q.push_back(22'($urandom())); disp_q.push_back(22'($urandom()));
            fwr_q.push_back({22'($urandom()), $urandom(), $urandom()});
        end
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b0, 3'b111);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL full_vec: got %h exp %h", dut_vec, exp_vec());
            end
            if (mem_req_wr_en && mem_req_wr_cmd == CMD_READ) nrd++;
            if (mem_req_wr_en && mem_req_wr_cmd == CMD_WRITE) nwr++;
            if (mem_req_wr_en && mem_req_wr_cmd == CMD_REFRESH) nref++;
        end
        n_checks++;
        if (nrd !== TAGD || nwr < 10) begin
            n_fail++; $display("FAIL tag_full_block: got reads=%0d writes=%0d exp 4 and >=10", nrd, nwr);
        end
        n_checks++;
`ifdef MEM_ARB_REFRESH_EN
        if (nref < 2) begin
            n_fail++; $display("FAIL refresh_count: got %0d exp >=2", nref);
        end
`else
        if (nref !== 0) begin
            n_fail++; $display("FAIL refresh_count: got %0d exp 0", nref);
        end
`endif
        clear_reqs();
        for (int k = 0; k < TAGD; k++) res_q.push_back({$urandom(), $urandom()});
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 3'b111);
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL full_drain_vec: got %h exp %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        auto_resp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (fwr_q.size() < 4) fwr_q.push_back({22'($urandom()), $urandom(), $urandom()});
            if (mc_q.size() < 4) mc_q.push_back(22'($urandom()));
            if (disp_q.size() < 2 && $urandom_range(0, 3) == 0) disp_q.push_back(22'($urandom()));
            if ($urandom_range(0, 59) == 0) res_q.push_back({$urandom(), $urandom()});
            step((i != 200) ? 1'b1 : 1'b0, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 3'($urandom()));
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_vec(%0d): got %h exp %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_rr_priority();
        test_backpressure();
        test_read_route();
        test_tag_full();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
